// File: rtl/lector_catodo_pkg.sv
// Shared constants for the 7-segment scan reader: active-low segment patterns,
// digit codes, FSM states and strobe helpers.
package lector_catodo_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] DIG_DASH  = 4'd15;
  localparam logic [3:0] DIG_BLANK = 4'd14;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  // A strobe is meaningful only when exactly one active-low bit is asserted.
  function automatic logic anodo_ok(input logic [3:0] a);
    return (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
  endfunction

  function automatic logic [1:0] anodo_idx(input logic [3:0] a);
    logic [1:0] idx;
    case (a)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/lector_catodo_decod.sv
// Combinational segment-pattern to digit lookup.
// Define LECTOR_CATODO_BLANK_EN to accept the all-off pattern as digit 14 (blank).
module decod_catodo
  import lector_catodo_pkg::*;
(
  input  logic [6:0] catodo,
  output logic [3:0] digit,
  output logic       ok
);

`ifdef LECTOR_CATODO_BLANK_EN
  localparam logic BLANK_OK = 1'b1;
`else
  localparam logic BLANK_OK = 1'b0;
`endif

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    digit = 4'd0;
    ok    = 1'b1;
    case (catodo)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_DASH:  digit = DIG_DASH;
      SEG_BLANK: begin
        digit = BLANK_OK ? DIG_BLANK : 4'd0;
        ok    = BLANK_OK;
      end
      default:   ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/lector_catodo.sv
// Reads a multiplexed 4-digit 7-segment display: waits for a stable strobe,
// captures one digit per strobe period and flags completed frames.
module lector_catodo
  import lector_catodo_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  anodo,
  input  logic [6:0]  catodo,
  input  logic        clear,
  output logic [15:0] digitos,
  output logic [3:0]  valido,
  output logic        error,
  output logic        frame_done
);

  localparam logic [7:0] SETTLE_LIM = 8'(SETTLE_CYCLES);

  state_t      state_q, state_d;
  logic [10:0] snap_q;
  logic [7:0]  cnt_q;
  logic [3:0]  seen_q;

  logic [10:0] sample;
  logic        sel_ok, same, settled;
  logic        load_snap, inc_cnt, do_capture;
  logic [3:0]  dec_digit;
  logic        dec_ok;
  logic [1:0]  cap_idx;
  logic [3:0]  cap_bit;

  assign sample  = {anodo, catodo};
  assign sel_ok  = anodo_ok(anodo);
  assign same    = (sample == snap_q);
  assign settled = ((cnt_q + 8'd1) == SETTLE_LIM);
  assign cap_idx = anodo_idx(snap_q[10:7]);
  assign cap_bit = 4'b0001 << cap_idx;

  decod_catodo u_decod (
    .catodo (snap_q[6:0]),
    .digit  (dec_digit),
    .ok     (dec_ok)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst || clear) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_ok) state_d = (SETTLE_LIM == 8'd1) ? CAPTURE : SETTLE;
      SETTLE: begin
        if (same) begin
          if (settled) state_d = CAPTURE;
        end else if (!sel_ok) begin
          state_d = IDLE;
        end
      end
      CAPTURE: state_d = HOLD;
      HOLD:    if (!same) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_snap  = 1'b0;
    inc_cnt    = 1'b0;
    do_capture = 1'b0;
    case (state_q)
      IDLE:    load_snap  = sel_ok;
      SETTLE: begin
        load_snap = !same && sel_ok;
        inc_cnt   = same;
      end
      CAPTURE: do_capture = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q     <= '1;
      cnt_q      <= '0;
      seen_q     <= '0;
      digitos    <= '0;
      valido     <= '0;
      error      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (load_snap) begin
        snap_q <= sample;
        cnt_q  <= 8'd1;
      end else if (inc_cnt) begin
        cnt_q  <= cnt_q + 8'd1;
      end

      // A clear in the capture cycle discards that capture entirely.
      if (clear) begin
        digitos <= '0;
        valido  <= '0;
        error   <= 1'b0;
        seen_q  <= '0;
      end else if (do_capture) begin
        if (dec_ok) begin
          digitos[{cap_idx, 2'b00} +: 4] <= dec_digit;
          valido[cap_idx]                <= 1'b1;
        end else begin
          valido[cap_idx] <= 1'b0;
          error           <= 1'b1;
        end
        if ((seen_q | cap_bit) == 4'hF) begin
          seen_q     <= '0;
          frame_done <= 1'b1;
        end else begin
          seen_q <= seen_q | cap_bit;
        end
      end
    end
  end

endmodule

// File: tb/tb_lector_catodo.sv
// Directed self-checking bench for lector_catodo (SETTLE_CYCLES=4, plus a
// SETTLE_CYCLES=1 instance for the minimum-latency boundary).
module tb_lector_catodo;
  import lector_catodo_pkg::*;

  logic        clk = 1'b0;
  logic        rst, clear;
  logic [3:0]  anodo;
  logic [6:0]  catodo;
  logic [15:0] digitos, digitos1;
  logic [3:0]  valido, valido1;
  logic        error, error1, frame_done, frame_done1;

  int checks = 0;
  int failures = 0;
  int fd_count = 0;

  logic [6:0] segs [10] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4,
                            SEG_5, SEG_6, SEG_7, SEG_8, SEG_9};

  lector_catodo #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .anodo(anodo), .catodo(catodo), .clear(clear),
    .digitos(digitos), .valido(valido), .error(error), .frame_done(frame_done)
  );

  lector_catodo #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .anodo(anodo), .catodo(catodo), .clear(clear),
    .digitos(digitos1), .valido(valido1), .error(error1), .frame_done(frame_done1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_count++;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [3:0] a, input logic [6:0] c, input int hold, input int gap);
    anodo  = a;
    catodo = c;
    tick(hold);
    anodo  = 4'hF;
    catodo = 7'h7F;
    tick(gap);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; anodo = 4'hF; catodo = 7'h7F;
    tick(2);
    check("rst_digitos", digitos, 16'h0000);
    check("rst_valido", valido, 4'h0);
    check("rst_error", error, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    rst = 1'b0;
    tick(1);

    // Single digit: latency SETTLE_CYCLES+1 (5 here, 2 on the fast instance).
    anodo = 4'b1110; catodo = SEG_2;
    tick(1);
    check("fast_not_yet", valido1, 4'h0);
    tick(1);
    check("fast_digit", digitos1, 16'h0002);
    check("fast_valido", valido1, 4'h1);
    tick(2);
    check("lat4_not_yet", valido, 4'h0);
    tick(1);
    check("lat5_digit", digitos, 16'h0002);
    check("lat5_valido", valido, 4'h1);
    tick(1);
    anodo = 4'hF; catodo = 7'h7F;
    tick(2);
    check("single_no_frame", fd_count, 0);

    // Full scan 1,2,3,4 gives one frame pulse after digit 3.
    clear = 1'b1; tick(1); clear = 1'b0;
    check("clear_digitos", digitos, 16'h0000);
    for (int i = 0; i < 3; i++) strobe(4'hF ^ (4'b0001 << i), segs[i+1], 8, 2);
    check("scan_pre_frame", fd_count, 0);
    anodo = 4'b0111; catodo = SEG_4;
    tick(5);
    check("frame_pulse_hi", frame_done, 1'b1);
    tick(1);
    check("frame_pulse_lo", frame_done, 1'b0);
    tick(2);
    anodo = 4'hF; catodo = 7'h7F;
    tick(2);
    check("scan_digitos", digitos, 16'h4321);
    check("scan_valido", valido, 4'hF);
    check("scan_frames", fd_count, 1);

    // Undecodable pattern on digit 1; error is sticky across a good capture.
    strobe(4'b1101, 7'b1010101, 6, 2);
    check("bad_valido", valido, 4'b1101);
    check("bad_error", error, 1'b1);
    check("bad_digitos", digitos, 16'h4321);
    strobe(4'b1110, SEG_7, 6, 2);
    check("sticky_digitos", digitos, 16'h4327);
    check("sticky_error", error, 1'b1);
    clear = 1'b1; tick(1); clear = 1'b0;
    check("clear_error", error, 1'b0);
    check("clear_valido", valido, 4'h0);

    // Unstable segments and a multi-bit strobe never capture.
    anodo = 4'b1110;
    for (int k = 0; k < 6; k++) begin
      catodo = (k % 2 == 1) ? SEG_7 : SEG_1;
      tick(2);
    end
    anodo = 4'b1100; catodo = SEG_8;
    tick(10);
    anodo = 4'hF; catodo = 7'h7F;
    tick(2);
    check("unstable_digitos", digitos, 16'h0000);
    check("unstable_valido", valido, 4'h0);
    check("unstable_error", error, 1'b0);

    // Dash, then a clear landing in the capture cycle.
    strobe(4'b1110, SEG_DASH, 6, 2);
    check("dash_digitos", digitos, 16'h000F);
    check("dash_valido", valido, 4'h1);
    anodo = 4'b1011; catodo = SEG_5;
    tick(4);
    clear = 1'b1; anodo = 4'hF; catodo = 7'h7F;
    tick(1);
    clear = 1'b0;
    check("clrcap_digitos", digitos, 16'h0000);
    check("clrcap_valido", valido, 4'h0);
    check("clrcap_frame", frame_done, 1'b0);
    tick(3);
    check("clrcap_after", digitos, 16'h0000);

    // Reset in the middle of settling clears everything.
    strobe(4'b1110, SEG_9, 6, 2);
    strobe(4'b1011, 7'b1010101, 6, 2);
    check("pre_rst_digitos", digitos, 16'h0009);
    check("pre_rst_error", error, 1'b1);
    anodo = 4'b1101; catodo = SEG_3;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0; anodo = 4'hF; catodo = 7'h7F;
    check("rstmid_digitos", digitos, 16'h0000);
    check("rstmid_valido", valido, 4'h0);
    check("rstmid_error", error, 1'b0);
    check("rstmid_frame", frame_done, 1'b0);
    check("rstmid_fast_error", error1, 1'b0);
    check("rstmid_fast_frame", frame_done1, 1'b0);
    tick(5);
    check("rstmid_later", valido, 4'h0);

    // All-segments-off pattern on digit 3.
    strobe(4'b0111, SEG_BLANK, 6, 2);
`ifdef LECTOR_CATODO_BLANK_EN
    check("blank_digitos", digitos, 16'hE000);
    check("blank_valido", valido, 4'b1000);
    check("blank_error", error, 1'b0);
`else
    check("blank_digitos", digitos, 16'h0000);
    check("blank_valido", valido, 4'b0000);
    check("blank_error", error, 1'b1);
`endif
    check("total_frames", fd_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lector_catodo.md
LECTOR_CATODO -- requirements
Module: lector_catodo

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, is the number of consecutive identical samples required before a capture; legal range 1..255.
REQ-002 clk  input  1  sole clock; all logic rising-edge triggered.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 anodo  input  4  digit strobes, active-low; one bit low selects digit index 0..3.
REQ-005 catodo  input  7  segment pattern, active-low, bit6=a ... bit0=g.
REQ-006 clear  input  1  synchronous clear of all captured data.
REQ-007 digitos  output  16  captured digits, digit i in bits [4i+3:4i].
REQ-008 valido  output  4  per-digit flag: last capture for that digit decoded correctly.
REQ-009 error  output  1  sticky flag: an undecodable pattern was captured.
REQ-010 frame_done  output  1  one-cycle pulse: every digit captured since the last pulse.

Function
REQ-011 The block SHALL decode this pattern table: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 1111110->15 (dash); any other pattern is invalid.
REQ-012 anodo SHALL be valid only when exactly one bit is 0; all-ones or multiple zeros are treated as no digit selected.
REQ-013 The FSM SHALL have states IDLE, SETTLE, CAPTURE, HOLD.
REQ-014 IDLE: on valid anodo, snapshot {anodo,catodo}, set counter to 1, go SETTLE (or CAPTURE directly when SETTLE_CYCLES=1).
REQ-015 SETTLE: input equal to snapshot increments counter; when counter reaches SETTLE_CYCLES go CAPTURE.
REQ-016 SETTLE: input differing from snapshot with valid anodo reloads snapshot, counter=1, stays SETTLE; with invalid anodo goes IDLE.
REQ-017 CAPTURE (exactly one cycle): valid pattern writes the digit slot and sets its valido bit; invalid pattern leaves the slot unchanged, clears its valido bit, sets error; then go HOLD.
REQ-018 Outputs SHALL update on the clock edge ending the CAPTURE cycle; capture latency from the first stable sample is SETTLE_CYCLES+1 cycles.
REQ-019 HOLD: stay while input equals snapshot; on any difference go IDLE, so one strobe period yields at most one capture.
REQ-020 An internal 4-bit seen mask SHALL set the captured digit's bit on every capture; when the mask becomes 1111, frame_done SHALL pulse for one cycle aligned with the output update and the mask SHALL clear.
REQ-021 clear SHALL zero digitos, valido, error and the seen mask, and force IDLE; clear wins over a simultaneous capture.
REQ-022 error SHALL remain set until rst or clear.

Reset
REQ-023 rst SHALL force IDLE, counter 0, snapshot all-ones, seen mask 0, digitos=0, valido=0, error=0, frame_done=0.
REQ-024 rst asserted mid-SETTLE or in CAPTURE SHALL abort with no output update.

Configuration
REQ-025 Macro LECTOR_CATODO_BLANK_EN defined: pattern 1111111 decodes to 14 (blank), treated as valid.
REQ-026 Macro LECTOR_CATODO_BLANK_EN undefined: pattern 1111111 is invalid per REQ-017.

Structure
REQ-027 Shared package SHALL hold the pattern constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK), the FSM state enum, and the digit codes DIG_DASH=15, DIG_BLANK=14.
REQ-028 Combinational pattern-to-digit lookup SHALL be a sub-module decod_catodo with outputs digit[3:0] and ok.
REQ-029 Top-level SHALL hold FSM, counter, snapshot, seen mask and output registers.

Verification
REQ-030 SETTLE_CYCLES=4, anodo=1110, catodo=0010010 held 6 cycles -> digitos[3:0]=2, valido[0]=1 five cycles after first sample; exactly one capture.
REQ-031 Scan digits 0..3 with 1,2,3,4 (each held 8 cycles, 2-cycle all-ones gap) -> digitos=16'h4321, valido=1111, one frame_done pulse after digit 3.
REQ-032 anodo=1101, catodo=1010101 held 6 cycles -> valido[1]=0, error=1, digitos[7:4] unchanged; error stays 1 until clear.
REQ-033 catodo toggles every 2 cycles with SETTLE_CYCLES=4 -> no capture, outputs unchanged; anodo=1100 held 10 cycles -> no capture.
REQ-034 clear asserted in the CAPTURE cycle -> digitos=0, valido=0, no frame_done; rst mid-SETTLE -> all outputs 0, FSM IDLE.
REQ-035 With LECTOR_CATODO_BLANK_EN, anodo=0111, catodo=1111111 held 6 cycles -> digitos[15:12]=14, valido[3]=1, error=0; without the macro -> error=1.
